// File: rtl/btn_pkg.sv
// Shared FSM state encoding and default timing constants for the button pulser.
package btn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_REPEAT       = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_EN       = 1;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; output lags input by two clk edges.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_pulser.sv
// Debounced push-button to single-cycle pulse, with optional hold-to-repeat.
// First pulse appears DEBOUNCE_CYCLES+1 edges after btn_raw settles high; outputs are registered.
module btn_pulser
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pulse,
  output logic btn_level
);

  localparam int unsigned CNT_TOP = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int          CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          level_q, level_d;
  logic          btn_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_raw),
    .q_o (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // One counter serves both debounce windows and repeat intervals; every exit clears or seeds it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else if ((REPEAT_EN != 0) && (cnt_q == RD_LAST)) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REPEAT: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == RP_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RELEASE_WAIT: begin
        // A bounce back high restarts the hold timer rather than re-pulsing.
        if (btn_s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pulse     = pulse_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_btn_pulser.sv
// Scoreboard bench: two DUTs (repeat on/off) share one randomized button stream checked against a run-length model.
module tb_btn_pulser;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  typedef struct {
    int edge_n;
    bit p;
    bit l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic pulse0, lvl0, pulse1, lvl1;

  always #5 clk = ~clk;

  btn_pulser #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_rep (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .pulse(pulse0), .btn_level(lvl0));

  btn_pulser #(.DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_norep (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .pulse(pulse1), .btn_level(lvl1));

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   pulse_log0[$];
  int   pulse_cnt1 = 0;

  // Reference: level flips after D consecutive disagreeing samples of the synchronised button;
  // while accepted-high, repeats fire RD edges after the last anchor, then every RP edges.
  bit m_s1[2];
  bit m_s2[2];
  bit m_lvl[2];
  bit m_en[2];
  int m_run[2];
  int m_reps[2];
  int m_anchor[2];
  int m_edge = 0;

  task automatic model_edge(input int i, input bit raw, input bit r, output bit p, output bit l);
    bit bs;
    int el;
    p = 1'b0;
    if (r) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0;
      m_run[i] = 0; m_reps[i] = 0; m_anchor[i] = 0;
    end else begin
      bs = m_s2[i];
      if (bs != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = bs;
          m_run[i] = 0;
          if (bs) begin
            p = 1'b1;
            m_anchor[i] = m_edge;
            m_reps[i] = 0;
          end
        end
      end else begin
        if (m_lvl[i] && m_run[i] > 0) begin
          m_anchor[i] = m_edge;
          m_reps[i] = 0;
        end else if (m_lvl[i] && m_en[i]) begin
          el = m_edge - m_anchor[i];
          if (m_reps[i] == 0 && el == RD) begin
            p = 1'b1; m_reps[i] = 1; m_anchor[i] = m_edge;
          end else if (m_reps[i] > 0 && el == RP) begin
            p = 1'b1; m_anchor[i] = m_edge;
          end
        end
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw;
    end
    l = m_lvl[i];
  endtask

  task automatic step(input bit raw, input bit r);
    exp_t e;
    bit p, l;
    @(negedge clk);
    btn_raw = raw;
    rst = r;
    model_edge(0, raw, r, p, l);
    e.edge_n = m_edge; e.p = p; e.l = l;
    q0.push_back(e);
    model_edge(1, raw, r, p, l);
    e.p = p; e.l = l;
    q1.push_back(e);
    m_edge++;
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checks++;
        if (pulse0 !== e.p || lvl0 !== e.l) begin
          errors++;
          $display("FAIL rep edge %0d: pulse=%b level=%b, expected pulse=%b level=%b",
                   e.edge_n, pulse0, lvl0, e.p, e.l);
        end
        if (pulse0 === 1'b1) pulse_log0.push_back(e.edge_n);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checks++;
        if (pulse1 !== e.p || lvl1 !== e.l) begin
          errors++;
          $display("FAIL norep edge %0d: pulse=%b level=%b, expected pulse=%b level=%b",
                   e.edge_n, pulse1, lvl1, e.p, e.l);
        end
        if (pulse1 === 1'b1) pulse_cnt1++;
      end
    end
  end

  initial begin : stim
    int base;
    int hold_exp[8];
    int mode, len;
    bit lvl;
    hold_exp = '{5, 13, 16, 19, 22, 25, 28, 31};
    m_en[0] = 1'b1;
    m_en[1] = 1'b0;

    repeat (3) step(0, 1);
    repeat (5) step(0, 0);

    // Clean press: single pulse after edge 5.
    pulse_log0.delete();
    base = m_edge;
    repeat (10) step(1, 0);
    repeat (12) step(0, 0);
    drain();
    chk("clean_pulse_count", pulse_log0.size(), 1);
    if (pulse_log0.size() >= 1) chk("clean_pulse_edge", pulse_log0[0] - base, 5);

    // Press bounce never reaches acceptance.
    pulse_log0.delete();
    for (int k = 0; k < 6; k++) step((k % 2) == 0, 0);
    repeat (10) step(0, 0);
    drain();
    chk("bounce_pulse_count", pulse_log0.size(), 0);

    // Long hold with repeats.
    pulse_log0.delete();
    base = m_edge;
    repeat (30) step(1, 0);
    repeat (12) step(0, 0);
    drain();
    chk("hold_pulse_count", pulse_log0.size(), 8);
    for (int j = 0; j < 8; j++)
      if (j < pulse_log0.size()) chk($sformatf("hold_pulse_%0d", j), pulse_log0[j] - base, hold_exp[j]);

    // Release bounce while held.
    repeat (10) step(1, 0);
    repeat (2) step(0, 0);
    repeat (15) step(1, 0);
    repeat (12) step(0, 0);

    // Reset mid-press forces a full re-debounce.
    pulse_log0.delete();
    base = m_edge;
    for (int k = 0; k < 15; k++) step(1, k == 4);
    repeat (12) step(0, 0);
    drain();
    chk("reset_pulse_count", pulse_log0.size(), 1);
    if (pulse_log0.size() >= 1) chk("reset_pulse_edge", pulse_log0[0] - base, 10);

    // Repeat disabled: one pulse for a long hold.
    pulse_cnt1 = 0;
    repeat (40) step(1, 0);
    repeat (12) step(0, 0);
    drain();
    chk("norep_pulse_count", pulse_cnt1, 1);

    // Randomized segments: steady holds, chatter, and rare resets.
    repeat (150) begin
      mode = $urandom_range(0, 3);
      len  = $urandom_range(1, 25);
      lvl  = (mode == 1);
      for (int k = 0; k < len; k++) begin
        if (mode == 0) lvl = ~lvl;
        else if (mode == 3) lvl = $urandom_range(0, 1);
        step(lvl, $urandom_range(0, 99) == 0);
      end
    end
    repeat (12) step(0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
